spi_arbiter: RTL and testbench

Shares one `SPIMaster` instance between `NREQ` independent requesters (sensor/driver front-ends). Requesters post a word and frame length and wait for an acknowledge. The arbiter grants them round-robin, issues exactly one `stb_wr` per grant, and waits for `stb_rdy`. It then returns the received word and holds a guard gap so that the master's CS deasserts before the next frame. It sits between the requester logic and the `SPIMaster` control/data ports; the SPI pins remain on the master.

---
 rtl/spi_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Shares one SPIMaster between NREQ requesters. Requests are granted
//   round-robin. Each grant issues exactly one stb_wr and waits for stb_rdy.
//   The received word is then returned with a one-cycle ack. A guard gap
//   follows, so the master's CS deasserts before the next frame.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   req               per-requester request level (held until ack)
//   req_data          packed outgoing words, requester i at [i*TO_SPI_BITS +: TO_SPI_BITS]
//   req_len           packed frame bit counts, requester i at [i*LEN_W +: LEN_W]
//   ack               one-hot, one-cycle completion pulse
//   rsp_data          received word, valid with ack and held afterwards
//   rsp_timeout       qualifies ack as a timeout completion
//   busy              high whenever the arbiter is not idle
//   m_stb_wr          frame start strobe to the master
//   m_stb_rdy         frame complete strobe from the master
//   m_to_spi_data     outgoing word to the master
//   m_total_len       frame length to the master
//   m_from_spi_data   incoming word from the master
//
// Build option
//   SPI_ARB_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT cycles and
//                       completes with rsp_timeout=1 and rsp_data=0.
//                       When undefined, rsp_timeout is tied low.

module spi_arbiter #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned TO_SPI_BITS   = 8,
    parameter int unsigned FROM_SPI_BITS = 8,
    parameter int unsigned LEN_W         = $clog2(TO_SPI_BITS + FROM_SPI_BITS),
    parameter int unsigned GAP           = 64,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*TO_SPI_BITS-1:0]   req_data,
    input  logic [NREQ*LEN_W-1:0]         req_len,
    output logic [NREQ-1:0]               ack,
    output logic [FROM_SPI_BITS-1:0]      rsp_data,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic                          m_stb_wr,
    input  logic                          m_stb_rdy,
    output logic [TO_SPI_BITS-1:0]        m_to_spi_data,
    output logic [LEN_W-1:0]              m_total_len,
    input  logic [FROM_SPI_BITS-1:0]      m_from_spi_data
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned GAP_W = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_GAP
    } state_t;

    state_t                   state, state_n;
    logic [IDX_W-1:0]         ptr, ptr_n;          // last grant, doubles as grant index
    logic [GAP_W-1:0]         gap_cnt, gap_cnt_n;
    logic [NREQ-1:0]          ack_n;
    logic [FROM_SPI_BITS-1:0] rsp_data_n;
    logic                     busy_n;
    logic                     stb_wr_n;
    logic [TO_SPI_BITS-1:0]   to_data_n;
    logic [LEN_W-1:0]         total_len_n;

    logic                     found;
    logic [IDX_W-1:0]         pick;
    logic [IDX_W-1:0]         cand;
    logic [TO_SPI_BITS-1:0]   pick_data;
    logic [LEN_W-1:0]         pick_len;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]         wait_cnt, wait_cnt_n;
    logic                     timeout_n;
`endif

    // Round-robin search: start one past the last grant and wrap, so the
    // requester just served has the lowest priority on the next pass.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_data = req_data[pick*TO_SPI_BITS +: TO_SPI_BITS];
        pick_len  = req_len[pick*LEN_W +: LEN_W];
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        gap_cnt_n   = gap_cnt;
        ack_n       = '0;
        rsp_data_n  = rsp_data;
        stb_wr_n    = 1'b0;
        to_data_n   = m_to_spi_data;
        total_len_n = m_total_len;
`ifdef SPI_ARB_TIMEOUT_EN
        wait_cnt_n  = wait_cnt;
        timeout_n   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (found) begin
                    ptr_n       = pick;
                    to_data_n   = pick_data;
                    total_len_n = pick_len;
                    if (pick_len == '0) begin
                        // Nothing to shift: complete immediately with an empty word.
                        state_n     = S_DONE;
                        ack_n[pick] = 1'b1;
                        rsp_data_n  = '0;
                    end else begin
                        state_n  = S_ISSUE;
                        stb_wr_n = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                wait_cnt_n = '0;
`endif
            end
            S_WAIT: begin
                if (m_stb_rdy) begin
                    state_n    = S_DONE;
                    ack_n[ptr] = 1'b1;
                    rsp_data_n = m_from_spi_data;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_n    = S_DONE;
                    ack_n[ptr] = 1'b1;
                    rsp_data_n = '0;
                    timeout_n  = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_n   = S_GAP;
                gap_cnt_n = GAP_W'(GAP);
            end
            S_GAP: begin
                // Counter enters at GAP, so leaving when it would reach zero
                // gives exactly GAP cycles in this state.
                gap_cnt_n = gap_cnt - 1'b1;
                if (gap_cnt <= GAP_W'(1)) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n   = S_GAP;
                gap_cnt_n = GAP_W'(GAP);
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_GAP;
            ptr           <= IDX_W'(NREQ - 1);
            gap_cnt       <= GAP_W'(GAP);
            ack           <= '0;
            rsp_data      <= '0;
            busy          <= 1'b1;
            m_stb_wr      <= 1'b0;
            m_to_spi_data <= '0;
            m_total_len   <= '0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            gap_cnt       <= gap_cnt_n;
            ack           <= ack_n;
            rsp_data      <= rsp_data_n;
            busy          <= busy_n;
            m_stb_wr      <= stb_wr_n;
            m_to_spi_data <= to_data_n;
            m_total_len   <= total_len_n;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_n;
            rsp_timeout <= timeout_n;
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter
//   Directed scenarios followed by randomized traffic for spi_arbiter.
//   Expected grants come from a simple round-robin model over the set of
//   pending requesters. An inline SPI master answers each stb_wr.

module tb_spi_arbiter;

    localparam int NREQ = 4;
    localparam int TSB  = 8;
    localparam int FSB  = 8;
    localparam int LW   = 5;
    localparam int GAPC = 8;
    localparam int TOC  = 100;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*TSB-1:0]  req_data = '0;
    logic [NREQ*LW-1:0]   req_len = '0;
    logic [NREQ-1:0]      ack;
    logic [FSB-1:0]       rsp_data;
    logic                 rsp_timeout;
    logic                 busy;
    logic                 m_stb_wr;
    logic                 m_stb_rdy = 1'b0;
    logic [TSB-1:0]       m_to_spi_data;
    logic [LW-1:0]        m_total_len;
    logic [FSB-1:0]       m_from_spi_data = '0;

    int total = 0;
    int bad = 0;
    int stb_count = 0;
    int ack_count = 0;

    // Reference model state: who is pending and with what.
    int             ptr_m = NREQ - 1;
    bit             pend [NREQ];
    logic [TSB-1:0] d_m  [NREQ];
    logic [LW-1:0]  l_m  [NREQ];

    spi_arbiter #(
        .NREQ(NREQ),
        .TO_SPI_BITS(TSB),
        .FROM_SPI_BITS(FSB),
        .LEN_W(LW),
        .GAP(GAPC),
        .TIMEOUT(TOC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .req_len(req_len),
        .ack(ack),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .m_stb_wr(m_stb_wr),
        .m_stb_rdy(m_stb_rdy),
        .m_to_spi_data(m_to_spi_data),
        .m_total_len(m_total_len),
        .m_from_spi_data(m_from_spi_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_stb_wr === 1'b1) stb_count++;
        if (ack !== '0) ack_count++;
    endtask

    task automatic post(input int i, input logic [TSB-1:0] d, input logic [LW-1:0] l);
        pend[i] = 1'b1;
        d_m[i]  = d;
        l_m[i]  = l;
        req[i]  = 1'b1;
        req_data[i*TSB +: TSB] = d;
        req_len[i*LW +: LW]    = l;
    endtask

    task automatic drop(input int i);
        pend[i] = 1'b0;
        req[i]  = 1'b0;
    endtask

    function automatic int model_pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [LW-1:0] rand_len();
        if ($urandom_range(0, 5) == 0) return '0;
        return LW'($urandom_range(1, 31));
    endfunction

    // Advance until a frame strobe or an ack appears; n = cycles taken.
    task automatic next_event(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (m_stb_wr !== 1'b1 && ack === '0 && n < 400);
    endtask

    // Called on the cycle m_stb_wr is seen; plays the master for one frame.
    task automatic serve_frame(input int g, input logic [FSB-1:0] rdata, input int lat);
        chk("to_spi_data", m_to_spi_data, d_m[g]);
        chk("total_len", m_total_len, l_m[g]);
        tick();
        chk("stb_one_cycle", m_stb_wr, 1'b0);
        for (int i = 1; i < lat; i++) tick();
        m_stb_rdy       = 1'b1;
        m_from_spi_data = rdata;
        tick();
        m_stb_rdy       = 1'b0;
        m_from_spi_data = FSB'($urandom);
        chk("ack", ack, 32'(1) << g);
        chk("rsp_data", rsp_data, rdata);
        chk("rsp_timeout", rsp_timeout, 1'b0);
    endtask

    int n;
    int g;
    int sc;
    int ac;
    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            d_m[i]  = '0;
            l_m[i]  = '0;
        end

        // Reset state, then a single request from requester 0.
        reset = 1'b1;
        post(0, 8'hA5, 5'd16);
        tick();
        tick();
        chk("rst_ack", ack, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_stb_wr", m_stb_wr, 1'b0);
        chk("rst_to_spi_data", m_to_spi_data, '0);
        chk("rst_total_len", m_total_len, '0);
        chk("rst_busy", busy, 1'b1);
        tick();
        reset = 1'b0;
        ptr_m = NREQ - 1;
        next_event(n);
        chk("first_grant_latency", n, GAPC + 1);
        chk("t1_stb", m_stb_wr, 1'b1);
        serve_frame(0, 8'h3C, 4);
        ptr_m = 0;
        drop(0);
        tick();
        chk("t1_ack_pulse", ack, '0);
        chk("t1_rsp_hold", rsp_data, 8'h3C);
        chk("t1_stb_count", stb_count, 1);

        // Round robin with all four held continuously, starting from reset.
        for (int i = 0; i < NREQ; i++) post(i, TSB'(8'h10 + i), LW'(3 + i));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_event(n);
            chk("rr_spacing", n, (i == 0) ? GAPC + 1 : GAPC + 2);
            chk("rr_stb", m_stb_wr, 1'b1);
            serve_frame(rr_order[i], FSB'(8'hC0 + i), 1 + i);
        end

        // Priority rotation: grant 2, then 0101 wraps to 0 before 2.
        drop(0);
        drop(1);
        drop(3);
        next_event(n);
        chk("rot_spacing", n, GAPC + 2);
        serve_frame(2, 8'h21, 2);
        post(0, 8'h55, 5'd12);
        next_event(n);
        chk("rot_stb_a", m_stb_wr, 1'b1);
        serve_frame(0, 8'h22, 3);
        next_event(n);
        chk("rot_stb_b", m_stb_wr, 1'b1);
        serve_frame(2, 8'h23, 1);
        drop(0);
        drop(2);

        // Zero-length request: ack on the cycle after IDLE, no frame.
        post(1, 8'h77, 5'd0);
        sc = stb_count;
        for (int i = 0; i < GAPC; i++) tick();
        tick();
        chk("zero_idle", busy, 1'b0);
        tick();
        chk("zero_ack", ack, 4'b0010);
        chk("zero_rsp", rsp_data, '0);
        chk("zero_busy", busy, 1'b1);
        chk("zero_no_stb", stb_count, sc);
        ptr_m = 1;
        drop(1);

        // Reset in WAIT, stray stb_rdy afterwards, then requester 0 first.
        post(3, 8'h99, 5'd9);
        next_event(n);
        chk("rw_stb", m_stb_wr, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ptr_m = NREQ - 1;
        post(0, 8'h5A, 5'd10);
        m_stb_rdy       = 1'b1;
        m_from_spi_data = 8'hEE;
        ac = ack_count;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
            m_stb_rdy = 1'b0;
        end
        chk("rw_busy_cycles", n, GAPC);
        chk("rw_no_ack", ack_count, ac);
        tick();
        chk("rw_stb_after", m_stb_wr, 1'b1);
        serve_frame(0, 8'h6B, 2);
        ptr_m = 0;
        drop(0);

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            g = model_pick();
            sc = stb_count;
            next_event(n);
            chk("rand_spacing", n, GAPC + 2);
            if (l_m[g] == '0) begin
                chk("rand_zero_ack", ack, 32'(1) << g);
                chk("rand_zero_rsp", rsp_data, '0);
                chk("rand_zero_nostb", stb_count, sc);
            end else begin
                chk("rand_stb", m_stb_wr, 1'b1);
                serve_frame(g, FSB'($urandom), $urandom_range(1, 12));
            end
            ptr_m = g;
            if ($urandom_range(0, 1) == 1) post(g, TSB'($urandom), rand_len());
            else drop(g);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) post(i, TSB'($urandom), rand_len());
            end
            if (model_pick() < 0) post($urandom_range(0, NREQ - 1), TSB'($urandom), rand_len());
        end

`ifdef SPI_ARB_TIMEOUT_EN
        // No stb_rdy: timeout completion TOC+1 cycles after the strobe.
        for (int i = 0; i < NREQ; i++) drop(i);
        post(1, 8'h3E, 5'd6);
        next_event(n);
        chk("to_stb", m_stb_wr, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack === '0 && n < 400);
        chk("to_latency", n, TOC + 1);
        chk("to_ack", ack, 4'b0010);
        chk("to_flag", rsp_timeout, 1'b1);
        chk("to_rsp", rsp_data, '0);
        drop(1);
        tick();
        chk("to_flag_pulse", rsp_timeout, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
